// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state encoding and width defaults for the memory access stage
package mem_access_unit_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A command touches memory only when exactly one of load/store is requested.
  function automatic logic is_mem_cmd(input logic ld, input logic st);
    return ld ^ st;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - request-wait counter; flags the cycle that exhausts the allowed wait
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic limit_reached
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th consecutive un-acked request cycle.
  assign limit_reached = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access stage producing MDR; optional MEM_ACCESS_TIMEOUT_EN abort
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state;
  logic   timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic err_q;

  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk          (clk),
    .rst          (rst),
    .enable       ((state == ST_REQ) && !mem_ack),
    .clear        (state != ST_REQ),
    .limit_reached(timeout)
  );

  assign err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  // mem_addr/mem_wdata/mem_we double as the latched command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (is_mem_cmd(is_load, is_store)) begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= addr;
              mem_wdata <= wdata;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              mdr <= mem_rdata;
            end
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (timeout) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
          err_q <= 1'b0;
`endif
          state <= ST_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, is_load, is_store, mem_ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, mem_rdata;
  logic          mem_req, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mdr;

  mem_access_unit #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mdr(mdr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] mdr;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] mdr_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  // Monitor: every completion is matched against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("mdr_at_done", mdr, e.mdr);
        check("err_at_done", err, e.err);
      end
    end
    if (!rst && err && !done) check("err_without_done", 1, 0);
  end

  // kind: 0 load, 1 store, 2 both flags (NOP), 3 no flags (NOP)
  task automatic run_op(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waitc, input logic [DW-1:0] rd);
    exp_t e;
    int   c0;
    @(posedge clk); #1;
    start    = 1'b1;
    is_load  = (kind == 0 || kind == 2);
    is_store = (kind == 1 || kind == 2);
    addr     = a;
    wdata    = wd;
    c0       = cyc;
    if (kind >= 2) begin
      e.mdr = mdr_model; e.err = 1'b0; e.cyc = c0 + 1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      check("nop_no_req", mem_req, 0);
      check("nop_busy", busy, 1);
      is_load = 1'b1; is_store = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("nop_after_req", mem_req, 0);
      check("nop_after_busy", busy, 0);
    end else begin
      if (kind == 0) mdr_model = rd;
      e.mdr = mdr_model; e.err = 1'b0; e.cyc = c0 + waitc + 2;
      exp_q.push_back(e);
      for (int i = 0; i <= waitc; i++) begin
        @(posedge clk); #1;
        check("req_high", mem_req, 1);
        check("req_we", mem_we, (kind == 1));
        check("req_addr", mem_addr, a);
        check("req_wdata", mem_wdata, wd);
        start    = 1'($urandom_range(0, 1));
        is_load  = 1'($urandom);
        is_store = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
        mem_rdata = (i == waitc) ? rd : $urandom;
        mem_ack  = (i == waitc);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("done_cycle_req_low", mem_req, 0);
      start = 1'b1; is_load = 1'b1; is_store = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_req_low", mem_req, 0);
      check("idle_busy_low", busy, 0);
    end
  endtask

  task automatic stray_ack();
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_mdr", mdr, mdr_model);
    check("stray_busy", busy, 0);
    check("stray_req", mem_req, 0);
  endtask

  int   k, c0;
  exp_t te;

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mdr", mdr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    run_op(0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("load0_mdr", mdr, 32'hDEADBEEF);
    run_op(1, 32'h40, 32'h12345678, 3, 32'hCAFEF00D);
    check("store_mdr_kept", mdr, 32'hDEADBEEF);
    run_op(2, 32'h80, 32'h1, 0, 32'h0);
    run_op(3, 32'h84, 32'h2, 0, 32'h0);
    stray_ack();

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      k = (k < 4) ? 0 : (k < 8) ? 1 : (k == 8) ? 2 : 3;
      run_op(k, $urandom, $urandom, $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 4) == 0) stray_ack();
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; addr = 32'h200; c0 = cyc;
    te.mdr = mdr_model; te.err = 1'b1; te.cyc = c0 + TO + 1;
    exp_q.push_back(te);
    for (int i = 1; i <= TO; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("to_req_hold", mem_req, 1);
    end
    @(posedge clk); #1;
    check("to_req_drop", mem_req, 0);
    @(posedge clk); #1;
    check("to_idle_busy", busy, 0);
    run_op(0, 32'h204, 32'h0, TO - 1, 32'hA5A5A5A5);
`else
    run_op(0, 32'h200, 32'h0, 20, 32'hA5A5A5A5);
`endif

    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; addr = 32'h300;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_pre_req", mem_req, 1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_mdr", mdr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    mdr_model = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_req", mem_req, 0);
      check("post_rst_busy", busy, 0);
    end
    run_op(0, 32'h400, 32'h0, 1, 32'h0BADC0DE);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
